// File: rtl/arb_pkg.sv
// Shared definitions for the blram arbiter: default sizes and requester ids.
package arb_pkg;

  localparam int unsigned SIZE_DEF     = 14;
  localparam int unsigned DW_DEF       = 32;
  localparam int unsigned LOCK_MAX_DEF = 16;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  // Bits needed to count 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker with a bounded burst lock for port B.
module rr_arb2
  import arb_pkg::*;
#(
  parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic       b_req,
  input  logic       b_lock,
  output logic [1:0] gnt
);

  localparam int unsigned  CW      = cnt_width(LOCK_MAX);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);

  port_e         last_winner_q, last_winner_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          lock_full;
  logic          yield;

  // Grant selection and bookkeeping of winner history / lock length.
  always_comb begin
    gnt           = 2'b00;
    last_winner_d = last_winner_q;
    lock_cnt_d    = lock_cnt_q;
    lock_full     = (lock_cnt_q == CNT_MAX);
    // Forced hand-over to A once B has used up its lock budget.
    yield         = !rst && lock_full && a_req;

    if (!rst) begin
      if (a_req && b_req) begin
        if (b_lock && (lock_cnt_q < CNT_MAX)) begin
          gnt[PORT_B] = 1'b1;
        end else if (yield || (last_winner_q == PORT_B)) begin
          gnt[PORT_A] = 1'b1;
        end else begin
          gnt[PORT_B] = 1'b1;
        end
      end else if (a_req) begin
        gnt[PORT_A] = 1'b1;
      end else if (b_req && !yield) begin
        gnt[PORT_B] = 1'b1;
      end
    end

    if (gnt[PORT_A]) begin
      last_winner_d = PORT_A;
      lock_cnt_d    = '0;
    end else if (gnt[PORT_B]) begin
      last_winner_d = PORT_B;
      if (!b_lock) begin
        lock_cnt_d = '0;
      end else if (!lock_full) begin
        lock_cnt_d = lock_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_winner_q <= PORT_B;
      lock_cnt_q    <= '0;
    end else begin
      last_winner_q <= last_winner_d;
      lock_cnt_q    <= lock_cnt_d;
    end
  end

endmodule

// File: rtl/blram_arbiter.sv
// Shares one single-port blram between the CPU (port A) and a DMA/loader
// (port B); muxes the winner onto the RAM and steers read data back.
module blram_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned SIZE     = SIZE_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            a_req,
  input  logic            a_we,
  input  logic [SIZE-1:0] a_addr,
  input  logic [DW-1:0]   a_wdata,
  output logic            a_gnt,
  output logic            a_rvalid,
  output logic [DW-1:0]   a_rdata,

  input  logic            b_req,
  input  logic            b_we,
  input  logic [SIZE-1:0] b_addr,
  input  logic [DW-1:0]   b_wdata,
  input  logic            b_lock,
  output logic            b_gnt,
  output logic            b_rvalid,
  output logic [DW-1:0]   b_rdata,

  output logic            ram_we,
  output logic [SIZE-1:0] ram_addr,
  output logic [DW-1:0]   ram_wdata,
  input  logic [DW-1:0]   ram_rdata
);

  logic [1:0] gnt;
  logic       a_rvalid_q, a_rvalid_d;
  logic       b_rvalid_q, b_rvalid_d;

  rr_arb2 #(
    .LOCK_MAX (LOCK_MAX)
  ) u_rr (
    .clk    (clk),
    .rst    (rst),
    .a_req  (a_req),
    .b_req  (b_req),
    .b_lock (b_lock),
    .gnt    (gnt)
  );

  // RAM drive: B only when it wins, otherwise A's bus with writes gated off.
  always_comb begin
    a_gnt     = gnt[PORT_A];
    b_gnt     = gnt[PORT_B];
    ram_addr  = a_addr;
    ram_wdata = a_wdata;
    ram_we    = a_we && a_gnt;
    if (b_gnt) begin
      ram_addr  = b_addr;
      ram_wdata = b_wdata;
      ram_we    = b_we;
    end
    // One-hot return tag: which port owns the data arriving next cycle.
    a_rvalid_d = a_gnt && !a_we;
    b_rvalid_d = b_gnt && !b_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = ram_rdata;
  assign b_rdata  = ram_rdata;

endmodule

// File: tb/tb_blram_arbiter.sv
// Directed bench for blram_arbiter with a behavioural one-cycle-latency RAM.
module tb_blram_arbiter;

  localparam int unsigned SIZE = 14;
  localparam int unsigned DW   = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            a_req, a_we, b_req, b_we, b_lock;
  logic [SIZE-1:0] a_addr, b_addr;
  logic [DW-1:0]   a_wdata, b_wdata;
  logic            a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0]   a_rdata, b_rdata;
  logic            ram_we;
  logic [SIZE-1:0] ram_addr;
  logic [DW-1:0]   ram_wdata, ram_rdata;

  logic [DW-1:0]   mem [2**SIZE];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  blram_arbiter #(.SIZE(SIZE), .DW(DW), .LOCK_MAX(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_gnt     (a_gnt),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_lock    (b_lock),
    .b_gnt     (b_gnt),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Registered-read single-port RAM, like the blram instance.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    a_req = 1'b0; a_we = 1'b0; b_req = 1'b0; b_we = 1'b0; b_lock = 1'b0;
  endtask

  // A reads addr 4 while B bursts locked writes: 16 B grants, then A, then B.
  task automatic lock_run(input string tag);
    a_req = 1'b1; a_we = 1'b0; a_addr = 14'd4;
    b_req = 1'b1; b_we = 1'b1; b_lock = 1'b1; b_addr = 14'd9; b_wdata = 32'h0000_0099;
    for (int k = 0; k < 18; k++) begin
      #1;
      chk({tag, "_bgnt"}, 32'(b_gnt), 32'(k != 16));
      chk({tag, "_agnt"}, 32'(a_gnt), 32'(k == 16));
      tick;
      if (k == 16) begin
        chk({tag, "_arvalid"}, 32'(a_rvalid), 32'd1);
        chk({tag, "_ardata"}, a_rdata, 32'h1e);
      end
      chk({tag, "_brvalid"}, 32'(b_rvalid), 32'd0);
    end
    idle;
  endtask

  initial begin
    mem[1] = 32'h0;
    mem[3] = 32'h46;
    mem[4] = 32'h1e;
    mem[5] = 32'h8;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    idle;

    // Reset: grants and RAM write forced off even with requests pending.
    rst = 1'b1; a_req = 1'b1; a_we = 1'b1; b_req = 1'b1;
    tick; tick;
    chk("rst_agnt", 32'(a_gnt), 32'd0);
    chk("rst_bgnt", 32'(b_gnt), 32'd0);
    chk("rst_ramwe", 32'(ram_we), 32'd0);
    chk("rst_arvalid", 32'(a_rvalid), 32'd0);
    chk("rst_brvalid", 32'(b_rvalid), 32'd0);
    idle;
    rst = 1'b0;
    tick;

    // Idle: A's bus on the RAM, no write.
    a_addr = 14'd7; a_we = 1'b1;
    #1;
    chk("idle_gnt", 32'({a_gnt, b_gnt}), 32'd0);
    chk("idle_ramwe", 32'(ram_we), 32'd0);
    chk("idle_addr", 32'(ram_addr), 32'd7);
    a_we = 1'b0;

    // Single A read of addr 3.
    a_req = 1'b1; a_addr = 14'd3;
    #1;
    chk("t1_agnt", 32'(a_gnt), 32'd1);
    chk("t1_addr", 32'(ram_addr), 32'd3);
    tick;
    a_req = 1'b0;
    chk("t1_arvalid", 32'(a_rvalid), 32'd1);
    chk("t1_ardata", a_rdata, 32'h46);
    chk("t1_brvalid", 32'(b_rvalid), 32'd0);
    tick;
    chk("t1_arvalid_1cyc", 32'(a_rvalid), 32'd0);

    // Fresh reset so the first contention goes to A, then alternate.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    a_req = 1'b1; a_addr = 14'd4; b_req = 1'b1; b_addr = 14'd5;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("t2_agnt", 32'(a_gnt), 32'(k % 2 == 0));
      chk("t2_bgnt", 32'(b_gnt), 32'(k % 2 == 1));
      tick;
      chk("t2_arvalid", 32'(a_rvalid), 32'(k % 2 == 0));
      chk("t2_brvalid", 32'(b_rvalid), 32'(k % 2 == 1));
      if (k % 2 == 0) chk("t2_ardata", a_rdata, 32'h1e);
      else            chk("t2_brdata", b_rdata, 32'h8);
    end
    idle;

    // B writes addr 1, then A reads it back.
    b_req = 1'b1; b_we = 1'b1; b_addr = 14'd1; b_wdata = 32'hd001_0000;
    #1;
    chk("t3_bgnt", 32'(b_gnt), 32'd1);
    chk("t3_ramwe", 32'(ram_we), 32'd1);
    chk("t3_addr", 32'(ram_addr), 32'd1);
    chk("t3_wdata", ram_wdata, 32'hd001_0000);
    tick;
    chk("t3_wr_no_rvalid", 32'(b_rvalid), 32'd0);
    idle;
    a_req = 1'b1; a_addr = 14'd1;
    #1;
    chk("t3_agnt", 32'(a_gnt), 32'd1);
    chk("t3_ramwe_rd", 32'(ram_we), 32'd0);
    tick;
    idle;
    chk("t3_arvalid", 32'(a_rvalid), 32'd1);
    chk("t3_ardata", a_rdata, 32'hd001_0000);

    // Locked burst against a waiting A.
    lock_run("t4");

    // Lock with A idle for 40 cycles: B every cycle, counter saturates.
    b_req = 1'b1; b_we = 1'b1; b_lock = 1'b1; b_addr = 14'd9;
    for (int k = 0; k < 40; k++) begin
      #1;
      chk("t5_bgnt", 32'(b_gnt), 32'd1);
      chk("t5_agnt", 32'(a_gnt), 32'd0);
      tick;
    end
    // Saturated lock: A arriving is served at once (yield), then B resumes.
    a_req = 1'b1; a_addr = 14'd3;
    #1;
    chk("t5_yield_agnt", 32'(a_gnt), 32'd1);
    chk("t5_yield_bgnt", 32'(b_gnt), 32'd0);
    tick;
    #1;
    chk("t5_resume_bgnt", 32'(b_gnt), 32'd1);
    tick;
    idle;

    // An unlocked B grant clears the partial lock count.
    b_req = 1'b1; b_we = 1'b1; b_lock = 1'b1;
    for (int k = 0; k < 10; k++) tick;
    b_lock = 1'b0;
    tick;
    lock_run("t6");

    // Reset hits while an A read is granted: no rvalid, no write, A wins after.
    a_req = 1'b1; a_we = 1'b0; a_addr = 14'd3;
    #1;
    chk("t7_agnt", 32'(a_gnt), 32'd1);
    rst = 1'b1; a_we = 1'b1;
    #1;
    chk("t7_rst_agnt", 32'(a_gnt), 32'd0);
    chk("t7_rst_ramwe", 32'(ram_we), 32'd0);
    tick;
    chk("t7_arvalid", 32'(a_rvalid), 32'd0);
    rst = 1'b0; a_we = 1'b0; b_req = 1'b1; b_we = 1'b0;
    #1;
    chk("t7_first_agnt", 32'(a_gnt), 32'd1);
    chk("t7_first_bgnt", 32'(b_gnt), 32'd0);
    tick;
    idle;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/blram_arbiter.md
Name: blram_arbiter

Overview:
- Shares the single-port blram between two requesters: port A (VerySimpleCPU) and port B (DMA/debug loader that fills program memory at runtime).
- Grants at most one RAM access per cycle using round-robin arbitration.
- Port B may lock the RAM for bursts; the lock has a bounded length.
- Routes the one-cycle-latency read data back to the requester that issued the read. Sits between the requesters and the blram instance.

Parameters:
- SIZE, 14, RAM address width (blram depth = 2**SIZE).
- DW, 32, data width.
- LOCK_MAX, 16, maximum consecutive port-B grants under lock before a forced yield to A.

Ports:
- clk in 1: system clock, all state on rising edge.
- rst in 1: synchronous, active-high reset.
- a_req in 1: A requests an access; held with a_we/a_addr/a_wdata stable until a_gnt.
- a_we in 1: A access is a write.
- a_addr in SIZE: A word address.
- a_wdata in DW: A write data.
- a_gnt out 1: combinational; A's access is issued to the RAM this cycle.
- a_rvalid out 1: registered; a_rdata is valid (one cycle after a granted A read).
- a_rdata out DW: read data for A.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A signals, for port B.
- b_lock in 1: B requests back-to-back ownership while asserted.
- ram_we out 1: to blram i_we.
- ram_addr out SIZE: to blram i_addr.
- ram_wdata out DW: to blram i_ram_data_in.
- ram_rdata in DW: from blram o_ram_data_out (registered in the RAM, one-cycle latency).

Behaviour:
- Reset (clk edge with rst=1):
  - a_rvalid=b_rvalid=0.
  - last_winner=B, so A wins the first contention.
  - lock_cnt=0, yield=0.
  - a_gnt, b_gnt and ram_we are forced to 0 while rst=1.
- Grant, combinational each cycle:
  - Only one requester active: it wins, except B during a forced yield cycle (see lock rules).
  - Both active: B wins if b_lock=1, lock_cnt<LOCK_MAX and yield=0. Otherwise the requester that is not last_winner wins.
  - Exactly one of a_gnt/b_gnt is asserted when any request is grantable. Both are 0 when idle.
- RAM drive:
  - ram_addr/ram_wdata come from the winner's port.
  - When idle they come from port A, with ram_we=0.
  - ram_we = winner's we AND gnt.
- Read return:
  - A granted read sets the winner's rvalid on the next edge, for exactly 1 cycle.
  - a_rdata = b_rdata = ram_rdata, unqualified; rvalid qualifies the data.
  - A granted write never produces rvalid.
  - Back-to-back reads give back-to-back rvalid pulses.
- last_winner updates on every grant.
- Lock:
  - lock_cnt increments on each B grant while b_lock=1.
  - lock_cnt clears when B is granted with b_lock=0, or when A is granted.
  - lock_cnt==LOCK_MAX with a_req=1: yield=1 for one cycle. In that cycle A is granted and B is not, even if b_lock=1.
  - lock_cnt==LOCK_MAX with a_req=0: B keeps being granted and the counter saturates.
- Latency: grant in the same cycle as the request if it wins. Read data arrives 1 cycle after the grant.
- Starvation bound:
  - A waits at most LOCK_MAX+1 cycles.
  - B waits at most 1 cycle under contention.
- Reset mid-operation: a pending rvalid is dropped (cleared). No write is issued in the reset cycle.
- A requester dropping req before gnt is legal. No state is kept for it.

Decomposition:
- Shared package arb_pkg:
  - SIZE/DW defaults.
  - Port-id constants PORT_A=1'b0, PORT_B=1'b1.
  - LOCK_MAX default.
- One natural sub-module, rr_arb2:
  - Two-way round-robin picker holding last_winner, lock_cnt and yield.
  - Outputs the grant vector.
- The top level keeps the RAM muxing and the rvalid/return-tag registers.

Test Plan:
- Reset then A read addr 3 only (mem[3]=32'h46) -> a_gnt=1 same cycle, a_rvalid=1 next cycle with a_rdata=32'h46, b_rvalid=0.
- A and B both request reads every cycle (A addr 4, B addr 5) -> grants alternate A,B,A,B starting with A; rvalids alternate; a_rdata=32'h1e, b_rdata=32'h8.
- B writes 32'hd0010000 to addr 1 while A idle, then A reads addr 1 -> ram_we=1 only in B's grant cycle; A gets 32'hd0010000.
- b_lock=1, B continuous writes, A requesting -> exactly 16 consecutive b_gnt, then one a_gnt, then B resumes; A waits 17 cycles.
- b_lock=1 with a_req=0 for 40 cycles -> b_gnt every cycle, lock_cnt saturates at 16, no spurious a_gnt.
- A read granted, rst=1 on the next edge -> a_rvalid stays 0; after reset, first contention goes to A.
